// File: rtl/pwm_cap_pkg.sv
// rtl/pwm_cap_pkg.sv - shared constants and types for the PWM capture unit
//
// Purpose: default counter width, minimum prescale divide and the channel
// state encoding used by pwm_capture and pwm_cap_chan.
package pwm_cap_pkg;

  localparam int CNT_WIDTH_DEFAULT = 16;
  localparam int PSCR_MIN          = 2;

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } chan_state_e;

endpackage

// File: rtl/pwm_cap_chan.sv
// rtl/pwm_cap_chan.sv - one PWM capture channel
//
// Purpose: synchronises one PWM input, detects rising edges, counts period
// and high time in prescaler ticks and keeps sticky capture/overflow flags.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   en_i             global enable; low forces IDLE and clears counters
//   tick_i           shared prescaler tick
//   clr_i            clears capf_o/ovf_o (a coincident set wins)
//   pwm_i            asynchronous PWM input
//   per_o, high_o    last captured period / high time
//   valid_o          one-cycle pulse on each capture
//   capf_o, ovf_o    sticky capture / overflow flags
module pwm_cap_chan
  import pwm_cap_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic                 tick_i,
  input  logic                 clr_i,
  input  logic                 pwm_i,
  output logic [CNT_WIDTH-1:0] per_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 valid_o,
  output logic                 capf_o,
  output logic                 ovf_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 sync1_q, sync2_q, prev_q;
  chan_state_e          state_q;
  logic [CNT_WIDTH-1:0] cnt_q, hcnt_q, per_q, high_q;
  logic                 valid_q, capf_q, ovf_q;

  logic                 edge_d, cap_d, ovf_set_d;
  logic [CNT_WIDTH-1:0] cnt_d, hcnt_d, restart_d;

  assign edge_d = sync2_q & ~prev_q;
  // en_i gates the capture so an edge coinciding with disable is dropped
  assign cap_d  = en_i & (state_q == MEAS) & edge_d;

  // Saturating increments; counters never wrap
  assign cnt_d  = (tick_i && (cnt_q != CNT_MAX)) ? cnt_q + CNT_ONE : cnt_q;
  assign hcnt_d = (tick_i && sync2_q && (hcnt_q != CNT_MAX)) ? hcnt_q + CNT_ONE : hcnt_q;

  // The tick landing on the edge cycle already belongs to the new period
  assign restart_d = CNT_WIDTH'(tick_i);

  // Overflow fires on the cycle the period counter hits all-ones, so a
  // stuck line is reported without waiting for another edge
  assign ovf_set_d = en_i & (state_q == MEAS) & ~edge_d & tick_i &
                     (cnt_q == (CNT_MAX - CNT_ONE));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      per_q   <= '0;
      high_q  <= '0;
      valid_q <= 1'b0;
      capf_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= pwm_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= cap_d;
      capf_q  <= cap_d | (capf_q & ~clr_i);
      ovf_q   <= ovf_set_d | (ovf_q & ~clr_i);
      if (cap_d) begin
        per_q  <= cnt_q;
        high_q <= hcnt_q;
      end
      if (!en_i) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        hcnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            // First edge only arms the channel
            if (edge_d) begin
              state_q <= MEAS;
              cnt_q   <= restart_d;
              hcnt_q  <= restart_d;
            end
          end
          MEAS: begin
            if (edge_d) begin
              cnt_q  <= restart_d;
              hcnt_q <= restart_d;
            end else begin
              cnt_q  <= cnt_d;
              hcnt_q <= hcnt_d;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign per_o   = per_q;
  assign high_o  = high_q;
  assign valid_o = valid_q;
  assign capf_o  = capf_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - multi-channel PWM input capture top level
//
// Purpose: shared prescaler, NUM_CH capture channels and the level interrupt.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   en_i             global enable
//   pscr_i           prescaler divide value (0 and 1 behave as 2)
//   ovie_i, capie_i  overflow / capture interrupt enables
//   clr_i            per-channel flag clear pulses
//   pwm_i            asynchronous PWM inputs
//   per_o, high_o    captured period / high time, channel n at [n*CNT_WIDTH +: CNT_WIDTH]
//   valid_o          per-channel capture pulse
//   capf_o, ovf_o    sticky capture / overflow flags
//   irq_o            combined level interrupt
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        en_i,
  input  logic [CNT_WIDTH-1:0]        pscr_i,
  input  logic                        ovie_i,
  input  logic                        capie_i,
  input  logic [NUM_CH-1:0]           clr_i,
  input  logic [NUM_CH-1:0]           pwm_i,
  output logic [NUM_CH*CNT_WIDTH-1:0] per_o,
  output logic [NUM_CH*CNT_WIDTH-1:0] high_o,
  output logic [NUM_CH-1:0]           valid_o,
  output logic [NUM_CH-1:0]           capf_o,
  output logic [NUM_CH-1:0]           ovf_o,
  output logic                        irq_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] psc_q;
  logic [CNT_WIDTH-1:0] psc_reload_d;
  logic                 tick_d;

  // pscr_i is only sampled on reload, so a new value starts at the next period
  assign psc_reload_d = (pscr_i < CNT_WIDTH'(PSCR_MIN)) ? CNT_WIDTH'(PSCR_MIN - 1)
                                                        : pscr_i - CNT_ONE;
  // Counter sits at 0 after enable, so the first tick lands on the first cycle
  assign tick_d = en_i & (psc_q == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      psc_q <= '0;
    end else if (!en_i) begin
      psc_q <= '0;
    end else if (psc_q == '0) begin
      psc_q <= psc_reload_d;
    end else begin
      psc_q <= psc_q - CNT_ONE;
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
    pwm_cap_chan #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_chan (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .en_i   (en_i),
      .tick_i (tick_d),
      .clr_i  (clr_i[n]),
      .pwm_i  (pwm_i[n]),
      .per_o  (per_o[n*CNT_WIDTH +: CNT_WIDTH]),
      .high_o (high_o[n*CNT_WIDTH +: CNT_WIDTH]),
      .valid_o(valid_o[n]),
      .capf_o (capf_o[n]),
      .ovf_o  (ovf_o[n])
    );
  end

  assign irq_o = (ovie_i & (|ovf_o)) | (capie_i & (|capf_o));

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [CW-1:0]     pscr;
  logic              ovie, capie;
  logic [NCH-1:0]    clr, pwm;
  logic [NCH*CW-1:0] per_o, high_o;
  logic [NCH-1:0]    valid_o, capf_o, ovf_o;
  logic              irq_o;

  pwm_capture #(.NUM_CH(NCH), .CNT_WIDTH(CW)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .en_i   (en),
    .pscr_i (pscr),
    .ovie_i (ovie),
    .capie_i(capie),
    .clr_i  (clr),
    .pwm_i  (pwm),
    .per_o  (per_o),
    .high_o (high_o),
    .valid_o(valid_o),
    .capf_o (capf_o),
    .ovf_o  (ovf_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: ticks land on cycles m_start, m_start+P, ...; a rise
  // driven before posedge n is acted on at posedge n+2.
  typedef struct {
    int            ch;
    int            e;
    logic [CW-1:0] per;
    logic [CW-1:0] high;
  } cap_t;

  cap_t capq[$];
  int   m_start = 0;
  int   p_div   = 2;
  bit   en_m    = 0;
  bit   armed[NCH];
  int   e_last[NCH];
  int   h_len[NCH];

  function automatic int ticks(int a, int b);
    int lo, first, last;
    lo = (a > m_start) ? a : m_start;
    if (b < lo) return 0;
    first = (lo - m_start + p_div - 1) / p_div;
    last  = (b - m_start) / p_div;
    return (last < first) ? 0 : last - first + 1;
  endfunction

  function automatic logic [CW-1:0] sat(int c);
    return (c > MAX) ? CW'(MAX) : CW'(c);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    logic [NCH-1:0] expv;
    @(negedge clk);
    expv = '0;
    foreach (capq[i]) if (capq[i].e == cyc) expv[capq[i].ch] = 1'b1;
    chk("valid", 64'(valid_o), 64'(expv));
    for (int i = capq.size() - 1; i >= 0; i--) begin
      if (capq[i].e <= cyc) begin
        chk($sformatf("per[%0d]", capq[i].ch), 64'(per_o[capq[i].ch*CW +: CW]), 64'(capq[i].per));
        chk($sformatf("high[%0d]", capq[i].ch), 64'(high_o[capq[i].ch*CW +: CW]), 64'(capq[i].high));
        capq.delete(i);
      end
    end
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic set_en(input bit v);
    en   = v;
    en_m = v;
    if (v) begin
      m_start = cyc + 1;
      p_div   = (pscr < 2) ? 2 : int'(pscr);
    end else begin
      for (int i = 0; i < NCH; i++) armed[i] = 0;
      for (int i = capq.size() - 1; i >= 0; i--)
        if (capq[i].e >= cyc + 1) capq.delete(i);
    end
  endtask

  task automatic rise(input int ch, input int hi, output int e);
    cap_t c;
    e = cyc + 3;
    pwm[ch] = 1'b1;
    if (armed[ch]) begin
      c.ch   = ch;
      c.e    = e;
      c.per  = sat(ticks(e_last[ch], e - 1));
      c.high = sat(ticks(e_last[ch], e_last[ch] + h_len[ch] - 1));
      capq.push_back(c);
    end
    if (en_m) begin
      armed[ch]  = 1;
      e_last[ch] = e;
      h_len[ch]  = hi;
    end
  endtask

  task automatic period(input int ch, input int hi, input int lo);
    int e;
    rise(ch, hi, e);
    steps(hi);
    pwm[ch] = 1'b0;
    steps(lo);
  endtask

  task automatic clr_pulse(input logic [NCH-1:0] m);
    clr = m;
    step();
    clr = '0;
  endtask

  initial begin
    int e, c, ch, np;
    rst_n = 1'b0; en = 1'b0; pscr = CW'(2); ovie = 1'b0; capie = 1'b0;
    clr = '0; pwm = '0;
    steps(2);
    chk("rst per", 64'(per_o), 64'(0));
    chk("rst high", 64'(high_o), 64'(0));
    chk("rst capf", 64'(capf_o), 64'(0));
    chk("rst ovf", 64'(ovf_o), 64'(0));
    chk("rst irq", 64'(irq_o), 64'(0));
    rst_n = 1'b1;
    step();

    // pscr=2, period 20 high 6
    set_en(1);
    repeat (4) period(0, 6, 14);
    period(0, 6, 4);
    chk("t1 per", 64'(per_o[0 +: CW]), 64'(10));
    chk("t1 high", 64'(high_o[0 +: CW]), 64'(3));

    // pscr=0 behaves as 2
    set_en(0); pscr = CW'(0); step(); set_en(1);
    repeat (4) period(0, 4, 4);
    chk("t2 per", 64'(per_o[0 +: CW]), 64'(4));
    chk("t2 high", 64'(high_o[0 +: CW]), 64'(2));

    // disable coinciding with an edge, then re-enable
    rise(0, 4, e);
    steps(2);
    set_en(0);
    steps(2);
    pwm[0] = 1'b0;
    steps(10);
    chk("t5 hold per", 64'(per_o[0 +: CW]), 64'(4));
    chk("t5 hold high", 64'(high_o[0 +: CW]), 64'(2));
    set_en(1);
    period(0, 4, 4);
    period(0, 4, 4);
    chk("t5 per", 64'(per_o[0 +: CW]), 64'(4));

    // capture flag, interrupt and clear
    capie = 1'b1;
    clr_pulse('1);
    chk("t4 irq0", 64'(irq_o), 64'(0));
    period(2, 3, 5);
    rise(2, 3, e);
    steps(3);
    chk("t4 capf", 64'(capf_o[2]), 64'(1));
    chk("t4 irq1", 64'(irq_o), 64'(1));
    pwm[2] = 1'b0;
    steps(5);
    clr_pulse(4'b0100);
    chk("t4 capf clr", 64'(capf_o[2]), 64'(0));
    chk("t4 irq clr", 64'(irq_o), 64'(0));
    rise(2, 3, e);
    while (cyc < e - 1) step();
    clr = 4'b0100;
    step();
    clr = '0;
    chk("t4 set wins", 64'(capf_o[2]), 64'(1));
    pwm[2] = 1'b0;
    steps(4);

    // stuck-low line overflows
    set_en(0); step();
    clr_pulse('1);
    ovie = 1'b1; capie = 1'b0;
    set_en(1);
    rise(1, 3, e);
    steps(3);
    pwm[1] = 1'b0;
    for (int i = 0; i < 700; i++) begin
      step();
      c = ticks(e, cyc);
      chk("ovf1", 64'(ovf_o[1]), 64'(c >= MAX));
      chk("ovf irq", 64'(irq_o), 64'(c >= MAX));
      if (c >= MAX + 2) break;
    end
    chk("ovf reached", 64'(ticks(e, cyc) >= MAX), 64'(1));
    period(1, 3, 3);
    chk("ovf per", 64'(per_o[1*CW +: CW]), 64'(MAX));

    // randomized periods against the model
    for (int it = 0; it < 6; it++) begin
      set_en(0);
      pscr = CW'($urandom_range(0, 5));
      step();
      set_en(1);
      ch = $urandom_range(0, NCH - 1);
      np = $urandom_range(3, 5);
      for (int k = 0; k < np; k++)
        period(ch, $urandom_range(1, 12), $urandom_range(1, 12));
      period(ch, 2, 4);
    end

    // asynchronous reset mid-measurement
    set_en(0); pscr = CW'(2); step(); set_en(1);
    period(3, 2, 6);
    period(3, 2, 6);
    rise(3, 2, e);
    steps(2);
    pwm[3] = 1'b0;
    steps(4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst per", 64'(per_o), 64'(0));
    chk("arst high", 64'(high_o), 64'(0));
    chk("arst valid", 64'(valid_o), 64'(0));
    chk("arst capf", 64'(capf_o), 64'(0));
    chk("arst ovf", 64'(ovf_o), 64'(0));
    chk("arst irq", 64'(irq_o), 64'(0));
    capq.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < NCH; i++) armed[i] = 0;
    m_start = cyc + 1;
    period(3, 3, 5);
    chk("arst rearm", 64'(capf_o[3]), 64'(0));
    period(3, 3, 5);
    chk("arst per3", 64'(per_o[3*CW +: CW]), 64'(4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
